// File: rtl/gpio_apb_pkg.sv
// Shared definitions for the GPIO APB requester: FSM encoding, GPIO register map and default widths.
package gpio_apb_pkg;

  localparam int ADDR_W_DEF  = 3;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 16;

  localparam logic [ADDR_W_DEF-1:0] GPIO_DIR    = 3'd0;
  localparam logic [ADDR_W_DEF-1:0] GPIO_SET    = 3'd1;
  localparam logic [ADDR_W_DEF-1:0] GPIO_CLR    = 3'd2;
  localparam logic [ADDR_W_DEF-1:0] GPIO_STATUS = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/gpio_apb_master.sv
// APB requester for the GPIO slave: turns valid/ready commands into SETUP/ACCESS transfers
// and returns a one-cycle response, aborting after TIMEOUT wait states.
//
// state  | meaning
// IDLE   | bus quiet, ready for a command
// SETUP  | PSEL high, PENABLE low, address/data driven
// ACCESS | PSEL and PENABLE high, waiting for PREADY or timeout
module gpio_apb_master
  import gpio_apb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  apb_state_e       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             complete;
  logic             abort;

  // req_ready follows PREADY combinationally so a completing ACCESS can accept the next command
  assign req_ready = (state == IDLE) || ((state == ACCESS) && PREADY);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = SETUP;
      end
      SETUP: begin
        PSEL      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY) begin
          complete  = 1'b1;
          state_nxt = accept ? SETUP : IDLE;
        end else if (wait_cnt == TO_CNT) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
    end else if (accept) begin
      PADDR  <= req_addr;
      PWRITE <= req_write;
      PWDATA <= req_wdata;
    end
  end

  // Saturating wait-state counter; the abort fires on the ACCESS cycle that finds it at TIMEOUT
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= '0;
    end else if (accept) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !PREADY && (wait_cnt != TO_CNT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= complete || abort;
      rsp_rdata <= (complete && !PWRITE) ? PRDATA : '0;
      rsp_err   <= complete ? PSLVERR : abort;
    end
  end

endmodule
